sram_dp_cache_way: RTL and testbench

- Parametrised successor to the single-port cache-way SRAM model: one read/write port (port 0) plus one independent read-only port (port 1), sharing one clock.
- Adds deterministic behaviour the single-port model lacks: a post-reset zero-fill sequencer, output-valid strobes, and same-address write-first bypass between ports.
- Used as the per-way data/tag array for L1 D-cache and L1 I-cache. Port 1 serves the lookup pipeline. Port 0 serves refill and store traffic.

---
 rtl/sram_dp_cache_way.sv | 139 +++++++++++++
 tb/tb_sram_dp_cache_way.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_cache_way.sv
// Dual-port cache-way SRAM: port 0 read/write with lane masks, port 1 read-only.
// A post-reset sequencer zero-fills the array before any request is accepted.
module sram_dp_cache_way #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int RAM_DEPTH  = 128,
    parameter int WMASK_GRAN = 8,
    parameter int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  init_done
);

    localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic {
        ST_INIT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] fill_cnt;

    // NOTE: the array has no reset; the fill sequencer clears it after reset instead.
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  csb0_q, web0_q, csb1_q;
    logic [NUM_WMASKS-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
    logic [DATA_WIDTH-1:0] din0_q;

    logic                  rd0, wr0, rd1;
    logic                  in_range0, in_range1;
    logic [IDX_W-1:0]      idx0, idx1;
    logic [DATA_WIDTH-1:0] rdata1;

    assign init_done = (state_q == ST_DONE);
    assign rd0       = !csb0_q && web0_q;
    assign wr0       = !csb0_q && !web0_q;
    assign rd1       = !csb1_q;
    assign idx0      = addr0_q[IDX_W-1:0];
    assign idx1      = addr1_q[IDX_W-1:0];

    // Out-of-range addresses only exist when the array is shallower than the address space.
    if (RAM_DEPTH < 2**ADDR_WIDTH) begin : g_partial
        assign in_range0 = ({1'b0, addr0_q} < (ADDR_WIDTH+1)'(RAM_DEPTH));
        assign in_range1 = ({1'b0, addr1_q} < (ADDR_WIDTH+1)'(RAM_DEPTH));
    end else begin : g_full
        assign in_range0 = 1'b1;
        assign in_range1 = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && fill_cnt == IDX_W'(RAM_DEPTH - 1)) begin
            state_d = ST_DONE;
        end
    end

    // Port 1 read data with write-first forwarding of a same-address port 0 write.
    always_comb begin
        rdata1 = '0;
        if (in_range1) begin
            rdata1 = mem[idx1];
            if (wr0 && addr0_q == addr1_q) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (wmask0_q[i]) begin
                        rdata1[i*WMASK_GRAN +: WMASK_GRAN] = din0_q[i*WMASK_GRAN +: WMASK_GRAN];
                    end
                end
            end
        end
    end

    // NOTE: every clocked assignment uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q     <= ST_INIT;
            fill_cnt    <= '0;
            csb0_q      <= 1'b1;
            csb1_q      <= 1'b1;
            dout0       <= '0;
            dout1       <= '0;
            dout0_valid <= 1'b0;
            dout1_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                fill_cnt <= fill_cnt + IDX_W'(1);
            end
            csb0_q      <= csb0 | ~init_done;
            csb1_q      <= csb1 | ~init_done;
            dout0_valid <= rd0;
            dout1_valid <= rd1;
            if (rd0) begin
                dout0 <= in_range0 ? mem[idx0] : '0;
            end
            if (rd1) begin
                dout1 <= rdata1;
            end
        end
    end

    // NOTE: payload registers need no reset; the registered selects gate their use.
    always_ff @(posedge clk0) begin
        web0_q   <= web0;
        wmask0_q <= wmask0;
        addr0_q  <= addr0;
        din0_q   <= din0;
        addr1_q  <= addr1;
    end

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (state_q == ST_INIT) begin
                mem[fill_cnt] <= '0;
            end else if (wr0 && in_range0) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (wmask0_q[i]) begin
                        mem[idx0][i*WMASK_GRAN +: WMASK_GRAN] <= din0_q[i*WMASK_GRAN +: WMASK_GRAN];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_dp_cache_way.sv
// Scoreboard bench for sram_dp_cache_way: a reference memory model predicts each read
// when it is issued; a negedge monitor matches strobes, data, latency and held outputs.
module tb_sram_dp_cache_way;

    localparam int DW    = 64;
    localparam int AW    = 8;
    localparam int DEPTH = 128;
    localparam int NM    = 8;

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          csb0 = 1'b1;
    logic          web0 = 1'b1;
    logic [NM-1:0] wmask0 = '0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] din0 = '0;
    logic          csb1 = 1'b1;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] dout0, dout1;
    logic          dout0_valid, dout1_valid, init_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;
    logic          rst_q = 1'b1;
    logic          due0, due1;

    sram_dp_cache_way #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (DEPTH),
        .WMASK_GRAN(8)
    ) dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .csb0       (csb0),
        .web0       (web0),
        .wmask0     (wmask0),
        .addr0      (addr0),
        .din0       (din0),
        .dout0      (dout0),
        .dout0_valid(dout0_valid),
        .csb1       (csb1),
        .addr1      (addr1),
        .dout1      (dout1),
        .dout1_valid(dout1_valid),
        .init_done  (init_done)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) begin
        cyc   <= cyc + 1;
        rst_q <= rst0;
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Monitor: a strobe must appear exactly when the oldest prediction is due.
    always @(negedge clk0) begin
        if (rst_q) begin
            last0 = '0;
            last1 = '0;
            check("rst_dout0", dout0, '0);
            check("rst_dout1", dout1, '0);
            check("rst_flags", {dout0_valid, dout1_valid, init_done}, '0);
        end else begin
            due0 = (q0.size() > 0) && (q0[0].cyc == cyc);
            if (due0 || dout0_valid) begin
                check("p0_valid", dout0_valid, due0);
                if (due0) begin
                    check("p0_data", dout0, q0[0].data);
                    last0 = q0[0].data;
                    void'(q0.pop_front());
                end
            end else begin
                check("p0_hold", dout0, last0);
            end
            due1 = (q1.size() > 0) && (q1[0].cyc == cyc);
            if (due1 || dout1_valid) begin
                check("p1_valid", dout1_valid, due1);
                if (due1) begin
                    check("p1_data", dout1, q1[0].data);
                    last1 = q1[0].data;
                    void'(q1.pop_front());
                end
            end else begin
                check("p1_hold", dout1, last1);
            end
        end
    end

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    // One request cycle on both ports; the model is updated and reads predicted in issue order.
    task automatic req(input bit en0, input bit wr, input logic [NM-1:0] wm,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit en1, input logic [AW-1:0] a1);
        exp_t e;
        step();
        csb0   = !en0;
        web0   = !wr;
        wmask0 = wm;
        addr0  = a0;
        din0   = d0;
        csb1   = !en1;
        addr1  = a1;
        if (en0 && wr && a0 < DEPTH) begin
            for (int i = 0; i < NM; i++) begin
                if (wm[i]) model[a0[6:0]][i*8 +: 8] = d0[i*8 +: 8];
            end
        end
        if (en1) begin
            e.cyc  = cyc + 2;
            e.data = (a1 < DEPTH) ? model[a1[6:0]] : '0;
            q1.push_back(e);
        end
        if (en0 && !wr) begin
            e.cyc  = cyc + 2;
            e.data = (a0 < DEPTH) ? model[a0[6:0]] : '0;
            q0.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(0, 0, '0, '0, '0, 0, '0);
    endtask

    // Called right after rst0 drops; port 1 requests issued during the fill must be dropped.
    task automatic wait_init();
        int got;
        got = -1;
        for (int k = 1; k <= 200; k++) begin
            step();
            csb0 = 1'b1;
            csb1 = 1'b1;
            if (init_done) begin
                got = k;
                break;
            end
            csb1  = 1'b0;
            addr1 = AW'(k % DEPTH);
        end
        check("init_cycles", got, 128);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset, zero-fill, then read back the whole array on port 1.
        step(); step(); step();
        rst0 = 1'b0;
        wait_init();
        for (int i = 0; i < DEPTH; i++) req(0, 0, '0, '0, '0, 1, AW'(i));

        // Masked writes, latency, and a no-op all-lanes-off write.
        req(1, 1, 8'hFF, 5, 64'h1122334455667788, 0, 0);
        req(1, 1, 8'h0F, 5, 64'h0, 0, 0);
        req(1, 0, 8'h00, 5, 64'h0, 0, 0);
        req(1, 1, 8'h00, 5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        req(1, 0, 8'h00, 5, 64'h0, 0, 0);

        // Same-address collision: port 1 sees the written lanes.
        req(1, 1, 8'hFF, 9, {16{4'hA}}, 0, 0);
        req(1, 1, 8'hF0, 9, {16{4'h5}}, 1, 9);
        req(1, 0, 8'h00, 9, 64'h0, 1, 9);
        idle(3);

        // A write in flight when reset arrives is discarded.
        step();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 8'hFF; addr0 = 3; din0 = 64'hDEAD_BEEF_0BAD_F00D;
        step();
        csb0 = 1'b1;
        rst0 = 1'b1;
        step(); step(); step();
        rst0 = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        wait_init();
        req(1, 0, 8'h00, 3, 64'h0, 1, 3);

        // Streaming: port 1 reads 0..15 while port 0 writes 64..79, then read back.
        for (int i = 0; i < 16; i++) req(1, 1, 8'hFF, AW'(i), DW'(i), 0, 0);
        for (int i = 0; i < 16; i++)
            req(1, 1, 8'hFF, AW'(64 + i), {8{8'(i)}} ^ 64'hF0F0_0F0F_A5A5_5A5A, 1, AW'(i));
        for (int i = 0; i < 16; i++) req(1, 0, 8'h00, AW'(64 + i), 64'h0, 1, AW'(79 - i));

        // Out-of-range address: reads return 0, writes are dropped (72 would be the alias).
        req(1, 0, 8'h00, 200, 64'h0, 1, 200);
        req(1, 1, 8'hFF, 200, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        req(1, 0, 8'h00, 72, 64'h0, 1, 72);
        req(1, 0, 8'h00, 200, 64'h0, 0, 0);
        idle(4);

        check("sb_drain", DW'(q0.size() + q1.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
